// File: rtl/arm_exec_unit.sv
// -----------------------------------------------------------------------------
// arm_exec_unit
//   Execute-stage datapath of the 5-stage ARM pipeline: operand-2 shifter,
//   4-bit-opcode ALU, registered NZCV flags (PSR) and the branch condition
//   handler for the instruction currently in ID.
//
// Ports
//   clk          system clock, PSR updates on the rising edge
//   reset        asynchronous, active-low; clears the PSR
//   alu_op       EX ALU opcode
//   s_bit        EX instruction updates the flags
//   pa           operand A (Rn)
//   pb           Rm value fed to the shifter
//   shift_field  instruction bits [11:0]
//   am           addressing / shift mode
//   cond         ID instruction condition field [31:28]
//   b_instr      ID instruction is B
//   bl_instr     ID instruction is BL
//   shifter_out  operand B for the ALU
//   alu_out      ALU result
//   alu_cc       combinational {N,Z,C,V} of the current operation
//   psr_cc       registered {N,Z,C,V}
//   branched     branch taken (flush IF/ID, select target PC)
//   bl_taken     taken branch is a BL (write return PC to R14)
// -----------------------------------------------------------------------------
module arm_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       alu_op,
   input  logic             s_bit,
   input  logic [WIDTH-1:0] pa,
   input  logic [WIDTH-1:0] pb,
   input  logic [11:0]      shift_field,
   input  logic [1:0]       am,
   input  logic [3:0]       cond,
   input  logic             b_instr,
   input  logic             bl_instr,
   output logic [WIDTH-1:0] shifter_out,
   output logic [WIDTH-1:0] alu_out,
   output logic [3:0]       alu_cc,
   output logic [3:0]       psr_cc,
   output logic             branched,
   output logic             bl_taken
);

   localparam int SHW = $clog2(WIDTH);

   // Rotate right via a doubled word so a rotation of 0 needs no special case.
   function automatic logic [WIDTH-1:0] ror_w(input logic [WIDTH-1:0] x,
                                              input logic [SHW-1:0]   r);
      logic [2*WIDTH-1:0] t;
      t = {x, x} >> r;
      return t[WIDTH-1:0];
   endfunction

   logic [3:0] psr_cc_q, psr_cc_d;

   // ------------------------------------------------------------------ shifter
   logic [SHW-1:0] sh_amt;
   logic [SHW-1:0] imm_rot;
   logic [WIDTH-1:0] imm_val;

   always_comb begin
      sh_amt      = shift_field[11:7];
      imm_rot     = {shift_field[11:8], 1'b0};
      imm_val     = {{(WIDTH-8){1'b0}}, shift_field[7:0]};
      shifter_out = pb;
      case (am)
         2'b00: shifter_out = ror_w(imm_val, imm_rot);
         2'b01: begin
            // Amount 0 is identity for every type (no RRX encoding here).
            if (sh_amt != '0) begin
               case (shift_field[6:5])
                  2'b00:   shifter_out = pb << sh_amt;
                  2'b01:   shifter_out = pb >> sh_amt;
                  2'b10:   shifter_out = $unsigned($signed(pb) >>> sh_amt);
                  default: shifter_out = ror_w(pb, sh_amt);
               endcase
            end
         end
         2'b10:   shifter_out = {{(WIDTH-12){1'b0}}, shift_field};
         default: shifter_out = pb;
      endcase
   end

   // ---------------------------------------------------------------------- ALU
   // All arithmetic ops are folded into x + y + c; subtraction uses y = ~B
   // so the carry-out is directly the ARM "not borrow" flag.
   logic [WIDTH-1:0] add_x, add_y;
   logic             add_c, arith;
   logic [WIDTH:0]   sum;
   logic             cin;

   always_comb begin
      cin   = psr_cc_q[1];   // carry-in always from the registered flags
      add_x = pa;
      add_y = shifter_out;
      add_c = 1'b0;
      arith = 1'b1;
      case (alu_op)
         4'b0000: add_c = 1'b0;
         4'b0001: add_c = cin;
         4'b0010: begin add_y = ~shifter_out; add_c = 1'b1; end
         4'b0011: begin add_y = ~shifter_out; add_c = cin;  end
         4'b0100: begin add_x = shifter_out; add_y = ~pa; add_c = 1'b1; end
         4'b0101: begin add_x = shifter_out; add_y = ~pa; add_c = cin;  end
         default: arith = 1'b0;
      endcase
      sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};

      alu_out = '0;
      case (alu_op)
         4'b0110: alu_out = pa & shifter_out;
         4'b0111: alu_out = pa | shifter_out;
         4'b1000: alu_out = pa ^ shifter_out;
         4'b1001: alu_out = pa;
         4'b1010: alu_out = shifter_out;
         4'b1011: alu_out = ~shifter_out;
         4'b1100: alu_out = pa & ~shifter_out;
         default: alu_out = arith ? sum[WIDTH-1:0] : '0;
      endcase

      alu_cc[3] = alu_out[WIDTH-1];
      alu_cc[2] = (alu_out == '0);
      if (arith) begin
         alu_cc[1] = sum[WIDTH];
         alu_cc[0] = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                     (alu_out[WIDTH-1] != add_x[WIDTH-1]);
      end else begin
         alu_cc[1] = psr_cc_q[1];
         alu_cc[0] = psr_cc_q[0];
      end
   end

   // ---------------------------------------------------------------------- PSR
   always_comb begin
      psr_cc_d = s_bit ? alu_cc : psr_cc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) psr_cc_q <= 4'b0000;
      else        psr_cc_q <= psr_cc_d;
   end

   assign psr_cc = psr_cc_q;

   // -------------------------------------------------------- condition handler
   // Flags of a flag-setting EX instruction are forwarded to the ID branch.
   logic [3:0] eff;
   logic       f_n, f_z, f_c, f_v, cond_true;

   always_comb begin
      eff = s_bit ? alu_cc : psr_cc_q;
      {f_n, f_z, f_c, f_v} = eff;
      case (cond)
         4'b0000: cond_true = f_z;
         4'b0001: cond_true = !f_z;
         4'b0010: cond_true = f_c;
         4'b0011: cond_true = !f_c;
         4'b0100: cond_true = f_n;
         4'b0101: cond_true = !f_n;
         4'b0110: cond_true = f_v;
         4'b0111: cond_true = !f_v;
         4'b1000: cond_true = f_c && !f_z;
         4'b1001: cond_true = !f_c || f_z;
         4'b1010: cond_true = (f_n == f_v);
         4'b1011: cond_true = (f_n != f_v);
         4'b1100: cond_true = !f_z && (f_n == f_v);
         4'b1101: cond_true = f_z || (f_n != f_v);
         4'b1110: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
      branched = (b_instr | bl_instr) & cond_true;
      bl_taken = bl_instr & cond_true;
   end

endmodule

// File: tb/tb_arm_exec_unit.sv
module tb_arm_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  alu_op;
   logic        s_bit;
   logic [31:0] pa, pb;
   logic [11:0] shift_field;
   logic [1:0]  am;
   logic [3:0]  cond;
   logic        b_instr, bl_instr;
   logic [31:0] shifter_out, alu_out;
   logic [3:0]  alu_cc, psr_cc;
   logic        branched, bl_taken;

   int n_cmp  = 0;
   int n_fail = 0;

   arm_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .alu_op(alu_op), .s_bit(s_bit),
      .pa(pa), .pb(pb), .shift_field(shift_field), .am(am),
      .cond(cond), .b_instr(b_instr), .bl_instr(bl_instr),
      .shifter_out(shifter_out), .alu_out(alu_out), .alu_cc(alu_cc),
      .psr_cc(psr_cc), .branched(branched), .bl_taken(bl_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [11:0] sf;
      logic [1:0]  am;
      logic [3:0]  cond;
      logic        bi;
      logic        bli;
      logic [31:0] e_sh;
      logic [31:0] e_alu;
      logic [3:0]  e_cc;
      logic        e_br;
      logic        e_bl;
      logic [3:0]  e_psr;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [11:0] sf, input logic [1:0] m,
                        input logic [3:0] c, input logic bi, input logic bli);
      alu_op = op; s_bit = s; pa = a; pb = b; shift_field = sf; am = m;
      cond = c; b_instr = bi; bl_instr = bli;
   endtask

   initial begin
      logic [15:0] cond_exp;

      //            op     s  pa            pb            sf      am     cond   b  bl  sh            alu           cc      br bl psr
      vecs[0]  = '{4'h1, 0, 32'h5,        32'h3,        12'h000, 2'b11, 4'hE, 0, 0, 32'h3,        32'h8,        4'b0000, 0, 0, 4'b0000};
      vecs[1]  = '{4'hA, 0, 32'h0,        32'h0,        12'h4FF, 2'b00, 4'hE, 0, 0, 32'hFF000000, 32'hFF000000, 4'b1000, 0, 0, 4'b0000};
      vecs[2]  = '{4'hA, 0, 32'h0,        32'h80000000, 12'h240, 2'b01, 4'hE, 0, 0, 32'hF8000000, 32'hF8000000, 4'b1000, 0, 0, 4'b0000};
      vecs[3]  = '{4'hA, 0, 32'h0,        32'h000000AB, 12'h460, 2'b01, 4'hE, 0, 0, 32'hAB000000, 32'hAB000000, 4'b1000, 0, 0, 4'b0000};
      vecs[4]  = '{4'h9, 0, 32'h0,        32'h12345678, 12'h060, 2'b01, 4'hE, 0, 0, 32'h12345678, 32'h0,        4'b0100, 0, 0, 4'b0000};
      vecs[5]  = '{4'h0, 0, 32'h10,       32'h0,        12'hABC, 2'b10, 4'hE, 0, 0, 32'h00000ABC, 32'h00000ACC, 4'b0000, 0, 0, 4'b0000};
      vecs[6]  = '{4'h4, 0, 32'hAB,       32'h0,        12'h0AB, 2'b00, 4'hE, 0, 0, 32'hAB,       32'h0,        4'b0110, 0, 0, 4'b0000};
      vecs[7]  = '{4'h0, 0, 32'hFFFFFFFF, 32'h80000000, 12'hFA0, 2'b01, 4'hE, 0, 0, 32'h1,        32'h0,        4'b0110, 0, 0, 4'b0000};
      vecs[8]  = '{4'h2, 0, 32'h0,        32'h1,        12'hF80, 2'b01, 4'hE, 0, 0, 32'h80000000, 32'h80000000, 4'b1001, 0, 0, 4'b0000};
      vecs[9]  = '{4'h2, 1, 32'h3,        32'h3,        12'h000, 2'b11, 4'h0, 1, 0, 32'h3,        32'h0,        4'b0110, 1, 0, 4'b0110};
      vecs[10] = '{4'h9, 0, 32'h1,        32'h0,        12'h000, 2'b11, 4'h0, 1, 0, 32'h0,        32'h1,        4'b0010, 1, 0, 4'b0110};
      vecs[11] = '{4'h0, 1, 32'h7FFFFFFF, 32'h1,        12'h000, 2'b11, 4'hB, 0, 1, 32'h1,        32'h80000000, 4'b1001, 0, 0, 4'b1001};
      vecs[12] = '{4'h0, 1, 32'h7FFFFFFF, 32'h1,        12'h000, 2'b11, 4'hA, 0, 1, 32'h1,        32'h80000000, 4'b1001, 1, 1, 4'b1001};
      vecs[13] = '{4'hC, 0, 32'hFF,       32'h0F,       12'h000, 2'b11, 4'hF, 1, 0, 32'h0F,       32'hF0,       4'b0001, 0, 0, 4'b1001};
      vecs[14] = '{4'hB, 0, 32'h0,        32'h0,        12'h000, 2'b11, 4'hE, 1, 0, 32'h0,        32'hFFFFFFFF, 4'b1001, 1, 0, 4'b1001};
      vecs[15] = '{4'hD, 0, 32'h5,        32'h5,        12'h000, 2'b11, 4'hC, 1, 0, 32'h5,        32'h0,        4'b0101, 1, 0, 4'b1001};
      vecs[16] = '{4'h0, 1, 32'hFFFFFFFF, 32'h2,        12'h000, 2'b11, 4'h8, 0, 1, 32'h2,        32'h1,        4'b0010, 1, 1, 4'b0010};
      vecs[17] = '{4'h1, 0, 32'h1,        32'h1,        12'h000, 2'b11, 4'h2, 1, 0, 32'h1,        32'h3,        4'b0000, 1, 0, 4'b0010};
      vecs[18] = '{4'h3, 0, 32'h5,        32'h2,        12'h000, 2'b11, 4'h3, 1, 0, 32'h2,        32'h3,        4'b0010, 0, 0, 4'b0010};
      vecs[19] = '{4'h5, 0, 32'h2,        32'h5,        12'h000, 2'b11, 4'h9, 1, 0, 32'h5,        32'h3,        4'b0010, 0, 0, 4'b0010};

      reset = 1'b0;
      drive(4'h0, 1'b0, 32'h0, 32'h0, 12'h0, 2'b11, 4'hF, 1'b0, 1'b0);
      #1;
      chk("reset psr_cc", {28'h0, psr_cc}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post-reset psr_cc", {28'h0, psr_cc}, 32'h0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(vecs[i].op, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].sf, vecs[i].am,
               vecs[i].cond, vecs[i].bi, vecs[i].bli);
         #1;
         chk($sformatf("vec%0d shifter_out", i), shifter_out, vecs[i].e_sh);
         chk($sformatf("vec%0d alu_out", i), alu_out, vecs[i].e_alu);
         chk($sformatf("vec%0d alu_cc", i), {28'h0, alu_cc}, {28'h0, vecs[i].e_cc});
         chk($sformatf("vec%0d branched", i), {31'h0, branched}, {31'h0, vecs[i].e_br});
         chk($sformatf("vec%0d bl_taken", i), {31'h0, bl_taken}, {31'h0, vecs[i].e_bl});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d psr_cc", i), {28'h0, psr_cc}, {28'h0, vecs[i].e_psr});
         $display("vec%0d op=%h a=%h b=%h sh=%h alu=%h cc=%b psr=%b br=%b bl=%b",
                  i, alu_op, pa, pb, shifter_out, alu_out, alu_cc, psr_cc, branched, bl_taken);
      end

      // Reset between edges while a flag-setting op is presented: reset wins.
      @(negedge clk);
      drive(4'h0, 1'b1, 32'h7FFFFFFF, 32'h1, 12'h0, 2'b11, 4'hE, 1'b0, 1'b0);
      #1;
      chk("pre-reset psr_cc holds C", {28'h0, psr_cc}, 32'h2);
      reset = 1'b0;
      #1;
      chk("async reset psr_cc", {28'h0, psr_cc}, 32'h0);
      @(posedge clk);
      #1;
      chk("reset over s_bit psr_cc", {28'h0, psr_cc}, 32'h0);
      $display("midreset psr=%b", psr_cc);
      @(negedge clk);
      reset = 1'b1;
      drive(4'h1, 1'b0, 32'h1, 32'h1, 12'h0, 2'b11, 4'hE, 1'b0, 1'b0);
      #1;
      chk("adc after reset alu_out", alu_out, 32'h2);
      $display("adc after reset alu=%h", alu_out);
      @(negedge clk);
      drive(4'h3, 1'b0, 32'h5, 32'h2, 12'h0, 2'b11, 4'hE, 1'b0, 1'b0);
      #1;
      chk("sbc Cin=0 alu_out", alu_out, 32'h2);
      $display("sbc after reset alu=%h", alu_out);

      // Condition sweep with clear flags: only NE CC PL VC LS GE GT AL hold.
      cond_exp = 16'h56AA;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         drive(4'h9, 1'b0, 32'h1, 32'h0, 12'h0, 2'b11, c[3:0], 1'b1, 1'b0);
         #1;
         chk($sformatf("cond%0d branched", c), {31'h0, branched}, {31'h0, cond_exp[c]});
         $display("cond=%h br=%b", cond, branched);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
